// File: rtl/branch_ctrl.sv
// Branch control sequencer: BHT-based fetch prediction plus EX-side mispredict
// detection, flush pulse, held redirect handshake and saturating statistics.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | accepting resolved branches from EX, no redirect outstanding
// REDIRECT | redirect held toward fetch until redir_ready; EX branches ignored
module branch_ctrl #(
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_pc,
    input  logic             if_is_br,
    input  logic [31:0]      if_imm,
    output logic             pred_taken,
    output logic [31:0]      pred_tgt,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_pred_taken,
    input  logic             taken_br,
    input  logic [31:0]      br_tgt_pc,
    output logic             redir_valid,
    output logic [31:0]      redir_pc,
    input  logic             redir_ready,
    output logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    logic                 accept;
    logic                 mispred;

    assign if_idx  = if_pc[BHT_IDX_W+1:2];
    assign ex_idx  = ex_pc[BHT_IDX_W+1:2];
    assign accept  = ex_valid && (state == IDLE);
    assign mispred = accept && (taken_br != ex_pred_taken);

    // Read sees the pre-edge table contents; a same-cycle update is not bypassed.
    always_comb begin
        pred_taken = if_is_br & bht[if_idx][1];
        pred_tgt   = pred_taken ? (if_pc + if_imm) : (if_pc + 32'd4);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mispred)     state_nxt = REDIRECT;
            REDIRECT: if (redir_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign redir_valid = (state == REDIRECT);
    assign busy        = (state == REDIRECT);

    always_ff @(posedge clk) begin
        if (reset) begin
            flush         <= 1'b0;
            redir_pc      <= 32'd0;
            br_count      <= '0;
            mispred_count <= '0;
            for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else begin
            flush <= mispred;
            if (mispred) redir_pc <= taken_br ? br_tgt_pc : (ex_pc + 32'd4);
            if (accept) begin
                if (taken_br) begin
                    if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'd1;
                end else begin
                    if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'd1;
                end
                if (br_count != '1) br_count <= br_count + CNT_W'(1);
                if (mispred && (mispred_count != '1))
                    mispred_count <= mispred_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: a default instance and a CNT_W=2 instance
// share stimulus; a reference model predicts BHT, counters and redirect PCs.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, if_imm, ex_pc, br_tgt_pc;
    logic        if_is_br, ex_valid, ex_pred_taken, taken_br, redir_ready;

    logic        pred_taken, redir_valid, flush, busy;
    logic [31:0] pred_tgt, redir_pc;
    logic [15:0] br_count, mispred_count;

    logic        pred_taken_s, redir_valid_s, flush_s, busy_s;
    logic [31:0] pred_tgt_s, redir_pc_s;
    logic [1:0]  br_count_s, mispred_count_s;

    int checks = 0;
    int failures = 0;

    // reference model
    logic [1:0]  m_bht [16];
    logic [15:0] m_br, m_mis;
    logic [1:0]  m_br_s, m_mis_s;
    logic        m_busy, m_flush;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_is_br(if_is_br), .if_imm(if_imm),
        .pred_taken(pred_taken), .pred_tgt(pred_tgt), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .taken_br(taken_br), .br_tgt_pc(br_tgt_pc),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_ready(redir_ready),
        .flush(flush), .busy(busy), .br_count(br_count), .mispred_count(mispred_count)
    );

    branch_ctrl #(.BHT_IDX_W(4), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .if_pc(if_pc), .if_is_br(if_is_br), .if_imm(if_imm),
        .pred_taken(pred_taken_s), .pred_tgt(pred_tgt_s), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_pred_taken(ex_pred_taken), .taken_br(taken_br), .br_tgt_pc(br_tgt_pc),
        .redir_valid(redir_valid_s), .redir_pc(redir_pc_s), .redir_ready(redir_ready),
        .flush(flush_s), .busy(busy_s), .br_count(br_count_s), .mispred_count(mispred_count_s)
    );

    // Advance the model by one edge from the currently driven inputs, then the clock.
    task automatic tick();
        logic       acc, mis;
        logic [3:0] idx;
        acc = ex_valid && !m_busy && !reset;
        mis = acc && (taken_br != ex_pred_taken);
        idx = ex_pc[5:2];
        if (reset) begin
            for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
            m_br = 0; m_mis = 0; m_br_s = 0; m_mis_s = 0;
            m_busy = 0;
            exp_q.delete();
        end else begin
            if (acc) begin
                if (taken_br && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
                else if (!taken_br && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
                if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
                if (m_br_s != 2'd3) m_br_s = m_br_s + 2'd1;
                if (mis) begin
                    if (m_mis != 16'hFFFF) m_mis = m_mis + 16'd1;
                    if (m_mis_s != 2'd3) m_mis_s = m_mis_s + 2'd1;
                end
            end
            if (mis) begin
                exp_q.push_back(taken_br ? br_tgt_pc : ex_pc + 32'd4);
                m_busy = 1'b1;
            end else if (m_busy && redir_ready) begin
                m_busy = 1'b0;
            end
        end
        m_flush = mis && !reset;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [31:0] pc, input logic pt, input logic tk,
                            input logic [31:0] tgt);
        ex_valid = 1'b1; ex_pc = pc; ex_pred_taken = pt; taken_br = tk; br_tgt_pc = tgt;
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic bad;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        if_pc = 32'h100; if_is_br = 1'b1; if_imm = 32'h40;
        #1;
        checks++; if (pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred_taken got=%0h exp=0", pred_taken); end
        checks++; if (pred_tgt !== 32'h104) begin failures++; $display("FAIL reset_pred_tgt got=%0h exp=104", pred_tgt); end
        checks++; if (redir_valid !== 1'b0 || flush !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got=%0b%0b%0b exp=000", redir_valid, flush, busy); end
        checks++; if (redir_pc !== 32'h0) begin failures++; $display("FAIL reset_redir_pc got=%0h exp=0", redir_pc); end
        checks++; if (br_count !== 16'd0 || mispred_count !== 16'd0) begin
            failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", br_count, mispred_count); end
        bad = 1'b0;
        for (int i = 0; i < 16; i++) if (dut.bht[i] !== 2'b01) bad = 1'b1;
        checks++; if (bad) begin failures++; $display("FAIL reset_bht got=nonzero_mismatch exp=all_01"); end
    endtask

    task automatic test_correct_nt();
        drive_br(32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (flush !== 1'b0 || redir_valid !== 1'b0) begin
            failures++; $display("FAIL nt_no_flush got=%0b%0b exp=00", flush, redir_valid); end
        checks++; if (br_count !== m_br || mispred_count !== m_mis) begin
            failures++; $display("FAIL nt_counts got=%0d/%0d exp=%0d/%0d", br_count, mispred_count, m_br, m_mis); end
        checks++; if (dut.bht[0] !== 2'b00) begin failures++; $display("FAIL nt_bht0 got=%0b exp=00", dut.bht[0]); end
    endtask

    task automatic test_taken_mispredict();
        logic [31:0] exp;
        redir_ready = 1'b1;
        drive_br(32'h200, 1'b0, 1'b1, 32'h180);
        checks++; if (flush !== 1'b1 || redir_valid !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL tm_req got=%0b%0b%0b exp=111", flush, redir_valid, busy); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        checks++; if (redir_pc !== exp) begin failures++; $display("FAIL tm_redir_pc got=%0h exp=%0h", redir_pc, exp); end
        tick();
        checks++; if (redir_valid !== 1'b0 || busy !== 1'b0 || flush !== 1'b0) begin
            failures++; $display("FAIL tm_done got=%0b%0b%0b exp=000", redir_valid, busy, flush); end
        checks++; if (mispred_count !== 16'd1 || mispred_count !== m_mis) begin
            failures++; $display("FAIL tm_mis_count got=%0d exp=%0d", mispred_count, m_mis); end
        redir_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        logic [15:0] br_before;
        redir_ready = 1'b0;
        drive_br(32'h300, 1'b1, 1'b0, 32'h0);
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
        br_before = br_count;
        for (int i = 0; i < 4; i++) begin
            checks++; if (redir_valid !== 1'b1 || redir_pc !== exp) begin
                failures++; $display("FAIL bp_hold%0d got=%0b/%0h exp=1/%0h", i, redir_valid, redir_pc, exp); end
            checks++; if (flush !== (i == 0) || flush !== m_flush) begin
                failures++; $display("FAIL bp_flush%0d got=%0b exp=%0b", i, flush, (i == 0)); end
            if (i == 1) begin
                ex_valid = 1'b1; ex_pc = 32'h144; ex_pred_taken = 1'b0; taken_br = 1'b1; br_tgt_pc = 32'h500;
            end
            redir_ready = (i == 3);
            tick();
            ex_valid = 1'b0;
        end
        redir_ready = 1'b0;
        checks++; if (redir_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL bp_release got=%0b%0b exp=00", redir_valid, busy); end
        checks++; if (br_count !== br_before || br_count !== m_br || mispred_count !== m_mis) begin
            failures++; $display("FAIL bp_ignored_counts got=%0d/%0d exp=%0d/%0d", br_count, mispred_count, m_br, m_mis); end
        checks++; if (dut.bht[1] !== 2'b01 || dut.bht[1] !== m_bht[1]) begin
            failures++; $display("FAIL bp_ignored_bht got=%0b exp=01", dut.bht[1]); end
    endtask

    task automatic test_training();
        drive_br(32'h144, 1'b1, 1'b1, 32'h134);
        checks++; if (dut.bht[1] !== 2'b10) begin failures++; $display("FAIL tr_bht_step1 got=%0b exp=10", dut.bht[1]); end
        drive_br(32'h144, 1'b1, 1'b1, 32'h134);
        checks++; if (dut.bht[1] !== 2'b11 || dut.bht[1] !== m_bht[1]) begin
            failures++; $display("FAIL tr_bht_step2 got=%0b exp=11", dut.bht[1]); end
        drive_br(32'h144, 1'b1, 1'b1, 32'h134);
        checks++; if (dut.bht[1] !== 2'b11) begin failures++; $display("FAIL tr_bht_sat got=%0b exp=11", dut.bht[1]); end
        checks++; if (flush !== 1'b0 || redir_valid !== 1'b0) begin
            failures++; $display("FAIL tr_no_redirect got=%0b%0b exp=00", flush, redir_valid); end
        if_pc = 32'h144; if_is_br = 1'b1; if_imm = 32'hFFFF_FFF0;
        #1;
        checks++; if (pred_taken !== 1'b1 || pred_tgt !== 32'h134) begin
            failures++; $display("FAIL tr_pred got=%0b/%0h exp=1/134", pred_taken, pred_tgt); end
        if_is_br = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0 || pred_tgt !== 32'h148) begin
            failures++; $display("FAIL tr_not_branch got=%0b/%0h exp=0/148", pred_taken, pred_tgt); end
        if_is_br = 1'b1;
        // not-taken update to the entry being read: read keeps the old value this cycle
        ex_valid = 1'b1; ex_pc = 32'h144; ex_pred_taken = 1'b1; taken_br = 1'b1;
        ex_pred_taken = 1'b0; taken_br = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b1) begin failures++; $display("FAIL col_old_value got=%0b exp=1", pred_taken); end
        tick();
        ex_valid = 1'b0;
        checks++; if (dut.bht[1] !== m_bht[1] || dut.bht[1] !== 2'b10) begin
            failures++; $display("FAIL col_after got=%0b exp=10", dut.bht[1]); end
        if_pc = 32'hFFFF_FFFC; if_imm = 32'h8;
        #1;
        checks++; if (pred_taken !== 1'b0 || pred_tgt !== 32'h0) begin
            failures++; $display("FAIL wrap_pred got=%0b/%0h exp=0/0", pred_taken, pred_tgt); end
        if_pc = 32'hFFFF_FFC4; if_imm = 32'h100;
        #1;
        checks++; if (pred_taken !== 1'b1 || pred_tgt !== 32'h0000_00C4) begin
            failures++; $display("FAIL wrap_taken got=%0b/%0h exp=1/c4", pred_taken, pred_tgt); end
    endtask

    task automatic test_saturation();
        logic [31:0] exp;
        logic        bad;
        reset = 1'b1; tick(); reset = 1'b0;
        redir_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive_br(32'h40 + 32'(k * 4), 1'b0, 1'b1, 32'h800 + 32'(k * 16));
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            checks++; if (redir_valid_s !== 1'b1 || redir_pc_s !== exp || redir_pc !== exp) begin
                failures++; $display("FAIL sat_redir%0d got=%0b/%0h exp=1/%0h", k, redir_valid_s, redir_pc_s, exp); end
            tick();
        end
        checks++; if (br_count_s !== 2'd3 || mispred_count_s !== 2'd3 || br_count_s !== m_br_s) begin
            failures++; $display("FAIL sat_small got=%0d/%0d exp=3/3", br_count_s, mispred_count_s); end
        checks++; if (br_count !== 16'd5 || mispred_count !== m_mis) begin
            failures++; $display("FAIL sat_wide got=%0d/%0d exp=5/%0d", br_count, mispred_count, m_mis); end
        redir_ready = 1'b0;
        drive_br(32'h60, 1'b1, 1'b0, 32'h0);
        checks++; if (redir_valid !== 1'b1 || busy_s !== 1'b1) begin
            failures++; $display("FAIL sat_in_redirect got=%0b%0b exp=11", redir_valid, busy_s); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (redir_valid !== 1'b0 || redir_valid_s !== 1'b0 || flush_s !== 1'b0) begin
            failures++; $display("FAIL rst_abandon got=%0b%0b%0b exp=000", redir_valid, redir_valid_s, flush_s); end
        checks++; if (br_count_s !== 2'd0 || mispred_count_s !== 2'd0 || br_count !== 16'd0) begin
            failures++; $display("FAIL rst_counts got=%0d/%0d/%0d exp=0/0/0", br_count_s, mispred_count_s, br_count); end
        bad = 1'b0;
        for (int i = 0; i < 16; i++) if (dut_s.bht[i] !== 2'b01 || dut.bht[i] !== m_bht[i]) bad = 1'b1;
        checks++; if (bad) begin failures++; $display("FAIL rst_bht got=mismatch exp=all_01"); end
    endtask

    initial begin
        reset = 1'b1; if_pc = 0; if_is_br = 0; if_imm = 0;
        ex_valid = 0; ex_pc = 0; ex_pred_taken = 0; taken_br = 0; br_tgt_pc = 0; redir_ready = 0;
        m_busy = 0; m_flush = 0; m_br = 0; m_mis = 0; m_br_s = 0; m_mis_s = 0;
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        @(negedge clk);
        test_reset();
        test_correct_nt();
        test_taken_mispredict();
        test_backpressure();
        test_training();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch control sequencer around the branch-resolution datapath.
- Fetch side: a direct-mapped table of 2-bit saturating counters (BHT) predicts each branch and supplies the predicted next PC.
- Execute side: compares the resolved direction (taken_br / br_tgt_pc from the branch unit) with the prediction. On a mismatch it issues a one-cycle flush and a held redirect request to fetch, using a valid/ready handshake.
- Keeps saturating branch and mispredict statistics.

Parameters:
BHT_IDX_W, 4, log2 of BHT entry count (16 entries by default)
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_pc  in  32  PC of the instruction being fetched
if_is_br  in  1  predecode says fetched instruction is a conditional branch
if_imm  in  32  branch offset of the fetched instruction
pred_taken  out  1  combinational prediction for if_pc
pred_tgt  out  32  combinational predicted next PC
ex_valid  in  1  a resolved conditional branch is present in EX this cycle
ex_pc  in  32  PC of the EX branch
ex_pred_taken  in  1  prediction carried down the pipe with the EX branch
taken_br  in  1  resolved direction from the branch unit
br_tgt_pc  in  32  resolved target from the branch unit
redir_valid  out  1  redirect request to fetch
redir_pc  out  32  redirect PC, valid while redir_valid
redir_ready  in  1  fetch accepts the redirect
flush  out  1  one-cycle pulse: kill younger in-flight instructions
busy  out  1  high in REDIRECT; EX must hold/ignore branches
br_count  out  CNT_W  accepted branches, saturating
mispred_count  out  CNT_W  mispredicted branches, saturating

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE.
  - redir_valid=0, redir_pc=0, flush=0, busy=0.
  - br_count=0, mispred_count=0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - Reset in REDIRECT abandons the pending redirect; the next cycle shows redir_valid=0.
- BHT index = pc[BHT_IDX_W+1:2]. PC bits [1:0] are ignored.
- Prediction (combinational):
  - pred_taken = if_is_br & bht[idx(if_pc)][1].
  - pred_tgt = if_pc+if_imm when pred_taken, else if_pc+4.
  - 32-bit modulo arithmetic; wrap-around is allowed.
- Branch acceptance: a branch is accepted when ex_valid=1 and state=IDLE. On the clock edge of acceptance:
  - bht[idx(ex_pc)] increments (saturating at 11) if taken_br=1, else decrements (saturating at 00).
  - br_count increments, saturating at all-ones.
  - If taken_br != ex_pred_taken, mispred_count increments (saturating) and state goes to REDIRECT.
- BHT read/write collision: a same-cycle read of the entry being written returns the old value (no bypass).
- FSM states IDLE, REDIRECT:
  - IDLE, accepted mispredict at cycle N:
    - At N+1: flush=1 for exactly one cycle, redir_valid=1, busy=1.
    - redir_pc = br_tgt_pc if taken_br, else ex_pc+4 (captured at N).
  - REDIRECT:
    - redir_valid and redir_pc are held stable until the cycle with redir_ready=1.
    - The handshake completes on that edge; the next cycle is IDLE with redir_valid=0 and busy=0.
    - redir_ready=1 in the first REDIRECT cycle gives a one-cycle request.
  - REDIRECT, ex_valid=1: ignored (wrong path). No BHT update, no counter change, no new redirect.
  - A correct prediction causes no flush, no redirect and no state change.
- redir_ready while in IDLE is ignored.
- Back-to-back mispredicts in consecutive IDLE cycles cannot occur: the second arrives while in REDIRECT and is dropped as above.

Test Plan:
1. Reset, then if_pc=0x100, if_is_br=1, if_imm=0x40 -> pred_taken=0, pred_tgt=0x104, redir_valid=0, flush=0, both counts 0.
2. Correct not-taken: ex_valid pulse with ex_pc=0x100, ex_pred_taken=0, taken_br=0 -> no flush, br_count=1, mispred_count=0, BHT[0]=00.
3. Taken mispredict: ex_pc=0x200, ex_pred_taken=0, taken_br=1, br_tgt_pc=0x180, redir_ready=1 ->
   - next cycle: flush=1, redir_valid=1, redir_pc=0x180.
   - cycle after: redir_valid=0, busy=0, mispred_count=1.
4. Backpressure: ex_pc=0x300, ex_pred_taken=1, taken_br=0, redir_ready low for 3 cycles then high ->
   - redir_valid=1 with redir_pc=0x304 held for 4 cycles; flush high only in the first.
   - An ex_valid pulse during the hold leaves br_count/BHT unchanged.
5. Training: two accepted taken branches at ex_pc=0x144 -> entry 1 goes 01->10->11. Then if_pc=0x144, if_is_br=1, if_imm=0xFFFFFFF0 -> pred_taken=1, pred_tgt=0x134.
6. Saturation/reset, CNT_W=2:
   - 5 mispredicts -> both counts stick at 3.
   - reset asserted while in REDIRECT -> next cycle redir_valid=0, counts=0, BHT entries 01.
